ex_operand_bypass: RTL and testbench
====================================

Name: ex_operand_bypass

Overview:
- Operand capture stage at the front of the execute pipeline, directly upstream of the operand-select mux wall.
- Accepts issued micro-ops carrying two source operands with producer tags.
- Bypasses writeback results into matching operands at capture time.
- Holds up to two ops in a snooping skid buffer, which keeps updating held operands from writeback until execute consumes them.

Parameters:
- WIDTH, 64, operand/data width in bits.
- TAG_W, 6, producer tag width; tag value 0 = "no producer" and never matches.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; discards all held and incoming ops.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  stage can accept an op this cycle.
- in_tag_a  in  TAG_W  producer tag of operand A.
- in_tag_b  in  TAG_W  producer tag of operand B.
- in_val_a  in  WIDTH  register-file value of operand A.
- in_val_b  in  WIDTH  register-file value of operand B.
- wb_valid  in  1  writeback broadcast valid.
- wb_tag  in  TAG_W  writeback producer tag.
- wb_data  in  WIDTH  writeback result.
- out_valid  out  1  head op valid toward execute.
- out_ready  in  1  execute consumes head op this cycle.
- out_a  out  WIDTH  head operand A.
- out_b  out  WIDTH  head operand B.

Behaviour:
- Reset:
  - count=0, out_valid=0, out_a=out_b=0, all entry valid bits 0.
  - in_ready=0 while reset is high and 1 the cycle after.
- Storage:
  - 2-entry in-order FIFO with head/tail pointers and count 0..2.
  - Each entry holds tag_a, tag_b, val_a, val_b.
- Handshakes:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_ready = (count != 2), derived from registered state only; there is no combinational path from out_ready.
  - out_valid = (count != 0).
  - When full, in_ready=0 even if a pop occurs the same cycle.
  - Simultaneous accept and pop at count=1 leaves count=1, with the new op becoming head.
- Capture bypass, per operand X:
  - Stored value = wb_data if wb_valid && wb_tag==in_tag_X && in_tag_X!=0.
  - Otherwise stored value = in_val_X.
- Snoop:
  - Each cycle, every valid entry whose tag_X matches (wb_valid && wb_tag==tag_X && tag_X!=0) overwrites val_X with wb_data.
  - Both operands of one entry may update in the same cycle.
  - An entry popped in the same cycle is not required to update.
- Latency:
  - An op accepted in cycle N appears at out_* in cycle N+1 when the buffer was empty.
  - A snoop update of the head is visible at out_* the cycle after the wb pulse.
- Outputs:
  - out_a/out_b are driven from the head entry.
  - They read 0 when count==0, so there is no stale data.
- Flush:
  - The next cycle has count=0, out_valid=0, outputs 0.
  - An accept in the flush cycle is discarded.
  - in_ready stays 1 during flush unless the buffer was full.
- Priority: reset > flush > pop/accept > snoop.
- Tag width: compare the full TAG_W bits; no wrap semantics.

Decomposition:
- Shared package: the tag zero constant NO_TAG and an entry struct {tag_a, tag_b, val_a, val_b} parameterized by WIDTH/TAG_W. Use a localparam-sized typedef, or a package typedef if widths are global.
- One natural sub-module: bypass_match (combinational tag compare + select for one operand).
  - Instantiate it for each capture operand and for each held entry's operand snoop.

Test Plan:
- Reset, then in_valid=1 with tags 0/0 and vals 0x11/0x22, out_ready=1 → out_valid=1 next cycle with out_a=0x11, out_b=0x22; the following cycle out_valid=0 and outputs are 0.
- Capture bypass: in_tag_a=5 while the same cycle has wb_valid=1, wb_tag=5, wb_data=0xAB, in_val_a=0x11 → out_a=0xAB, out_b unchanged.
- Snoop while stalled:
  - Stimulus: out_ready=0, push tag_b=7, in_val_b=0x3; two cycles later wb_tag=7, wb_data=0x99.
  - Response: out_b=0x99 the next cycle; out_a unchanged. Tag 0 with wb_tag=0 → no update.
- Full/backpressure:
  - Stimulus: out_ready=0, push ops A then B.
  - Response: in_ready=0 at count=2 even when out_ready rises; A pops, then B, in order; in_ready returns to 1 the cycle after the first pop.
- Flush mid-operation: count=2 and an accept in the same cycle as flush=1 → next cycle out_valid=0, count=0, the accepted op is never seen.
- Reset asserted with count=1 → next cycle out_valid=0, in_ready=0 while reset is high, 1 after release.

Source files
------------

// File: rtl/ex_operand_bypass_pkg.sv
// rtl/ex_operand_bypass_pkg.sv - shared constants for the operand capture/bypass stage
package ex_operand_bypass_pkg;

    localparam int NO_TAG = 0;

    typedef logic [1:0] count_t;

    localparam count_t DEPTH = 2'd2;

endpackage

// File: rtl/ex_operand_bypass_if.sv
// rtl/ex_operand_bypass_if.sv - issue, writeback and execute-side signals of the capture stage
interface ex_operand_bypass_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag_a;
    logic [TAG_W-1:0] in_tag_b;
    logic [WIDTH-1:0] in_val_a;
    logic [WIDTH-1:0] in_val_b;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [WIDTH-1:0] wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;

    modport master (
        output in_valid, in_tag_a, in_tag_b, in_val_a, in_val_b,
        output wb_valid, wb_tag, wb_data, out_ready,
        input  in_ready, out_valid, out_a, out_b
    );

    modport slave (
        input  in_valid, in_tag_a, in_tag_b, in_val_a, in_val_b,
        input  wb_valid, wb_tag, wb_data, out_ready,
        output in_ready, out_valid, out_a, out_b
    );
endinterface

// File: rtl/ex_operand_bypass_bypass_match.sv
// rtl/ex_operand_bypass_bypass_match.sv - tag compare and writeback select for one operand
module bypass_match
    import ex_operand_bypass_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
) (
    input  logic [TAG_W-1:0] tag,
    input  logic [WIDTH-1:0] val,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [WIDTH-1:0] wb_data,
    output logic [WIDTH-1:0] result
);
    logic hit;

    // Tag zero means the operand has no producer and must never pick up a broadcast.
    assign hit    = wb_valid && (wb_tag == tag) && (tag != TAG_W'(NO_TAG));
    assign result = hit ? wb_data : val;
endmodule

// File: rtl/ex_operand_bypass.sv
// rtl/ex_operand_bypass.sv - operand capture with writeback bypass and a 2-entry snooping skid buffer
module ex_operand_bypass
    import ex_operand_bypass_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    ex_operand_bypass_if.slave bus
);
    typedef struct packed {
        logic [TAG_W-1:0] tag_a;
        logic [TAG_W-1:0] tag_b;
        logic [WIDTH-1:0] val_a;
        logic [WIDTH-1:0] val_b;
    } entry_t;

    entry_t           ent_q [2];
    logic [1:0]       vld_q;
    logic             head_q;
    logic             tail_q;
    count_t           count_q;
    count_t           count_next;
    logic             rdy_q;
    logic             accept;
    logic             pop;
    logic [WIDTH-1:0] cap_a;
    logic [WIDTH-1:0] cap_b;
    logic [WIDTH-1:0] snp_a [2];
    logic [WIDTH-1:0] snp_b [2];

    bypass_match #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_cap_a (
        .tag(bus.in_tag_a), .val(bus.in_val_a), .wb_valid(bus.wb_valid),
        .wb_tag(bus.wb_tag), .wb_data(bus.wb_data), .result(cap_a)
    );

    bypass_match #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_cap_b (
        .tag(bus.in_tag_b), .val(bus.in_val_b), .wb_valid(bus.wb_valid),
        .wb_tag(bus.wb_tag), .wb_data(bus.wb_data), .result(cap_b)
    );

    for (genvar i = 0; i < 2; i++) begin : g_snoop
        bypass_match #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_snp_a (
            .tag(ent_q[i].tag_a), .val(ent_q[i].val_a), .wb_valid(bus.wb_valid),
            .wb_tag(bus.wb_tag), .wb_data(bus.wb_data), .result(snp_a[i])
        );
        bypass_match #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_snp_b (
            .tag(ent_q[i].tag_b), .val(ent_q[i].val_b), .wb_valid(bus.wb_valid),
            .wb_tag(bus.wb_tag), .wb_data(bus.wb_data), .result(snp_b[i])
        );
    end

    // in_ready is a flop so execute backpressure never reaches the issue side combinationally.
    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_a     = bus.out_valid ? ent_q[head_q].val_a : '0;
    assign bus.out_b     = bus.out_valid ? ent_q[head_q].val_b : '0;

    assign accept = bus.in_valid && rdy_q;
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        count_next = count_q;
        if (accept && !pop) begin
            count_next = count_q + 2'd1;
        end else if (pop && !accept) begin
            count_next = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                ent_q[i] <= '0;
            end
            vld_q   <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= '0;
            rdy_q   <= 1'b0;
        end else if (flush) begin
            vld_q   <= '0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= '0;
            rdy_q   <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (vld_q[i]) begin
                    ent_q[i].val_a <= snp_a[i];
                    ent_q[i].val_b <= snp_b[i];
                end
            end
            // The capture write lands after the snoop loop so a freshly filled slot takes the new op.
            if (accept) begin
                ent_q[tail_q] <= '{tag_a: bus.in_tag_a, tag_b: bus.in_tag_b,
                                   val_a: cap_a, val_b: cap_b};
                vld_q[tail_q] <= 1'b1;
                tail_q        <= ~tail_q;
            end
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q        <= ~head_q;
            end
            count_q <= count_next;
            rdy_q   <= (count_next != DEPTH);
        end
    end
endmodule

// File: tb/tb_ex_operand_bypass.sv
// tb/tb_ex_operand_bypass.sv - directed self-checking bench for ex_operand_bypass
module tb_ex_operand_bypass;
    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   tests = 0;
    int   fails = 0;

    ex_operand_bypass_if #(.WIDTH(64), .TAG_W(6)) bus ();

    ex_operand_bypass #(.WIDTH(64), .TAG_W(6)) dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [5:0] ta, input logic [5:0] tb, input logic [63:0] va,
                        input logic [63:0] vb);
        bus.in_valid = 1'b1;
        bus.in_tag_a = ta;
        bus.in_tag_b = tb;
        bus.in_val_a = va;
        bus.in_val_b = vb;
    endtask

    task automatic wb(input logic v, input logic [5:0] t, input logic [63:0] d);
        bus.wb_valid = v;
        bus.wb_tag   = t;
        bus.wb_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_tag_a = '0;
        bus.in_tag_b = '0;
        bus.in_val_a = '0;
        bus.in_val_b = '0;
        bus.out_ready = 1'b0;
        wb(1'b0, 6'd0, 64'd0);

        tick();
        tick();
        check("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_a", bus.out_a, 64'd0);
        reset = 1'b0;
        tick();
        check("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

        // basic pass-through
        push(6'd0, 6'd0, 64'h11, 64'h22);
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("basic_valid", 64'(bus.out_valid), 64'd1);
        check("basic_a", bus.out_a, 64'h11);
        check("basic_b", bus.out_b, 64'h22);
        tick();
        check("basic_drain_valid", 64'(bus.out_valid), 64'd0);
        check("basic_drain_a", bus.out_a, 64'd0);
        check("basic_drain_b", bus.out_b, 64'd0);

        // capture bypass
        push(6'd5, 6'd0, 64'h11, 64'h22);
        wb(1'b1, 6'd5, 64'hAB);
        tick();
        bus.in_valid = 1'b0;
        wb(1'b0, 6'd0, 64'd0);
        check("cap_bypass_a", bus.out_a, 64'hAB);
        check("cap_bypass_b", bus.out_b, 64'h22);
        tick();
        check("cap_bypass_drain", 64'(bus.out_valid), 64'd0);

        // snoop while stalled, tag-zero never matches
        bus.out_ready = 1'b0;
        push(6'd0, 6'd7, 64'h44, 64'h3);
        tick();
        bus.in_valid = 1'b0;
        check("snoop_pre_b", bus.out_b, 64'h3);
        tick();
        wb(1'b1, 6'd7, 64'h99);
        tick();
        check("snoop_b", bus.out_b, 64'h99);
        check("snoop_a_kept", bus.out_a, 64'h44);
        wb(1'b1, 6'd0, 64'h55);
        tick();
        wb(1'b0, 6'd0, 64'd0);
        check("snoop_tag0_a", bus.out_a, 64'h44);
        check("snoop_tag0_b", bus.out_b, 64'h99);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("snoop_drain", 64'(bus.out_valid), 64'd0);

        // both operands of one entry snooped together
        push(6'd9, 6'd9, 64'h1, 64'h2);
        tick();
        bus.in_valid = 1'b0;
        wb(1'b1, 6'd9, 64'h77);
        tick();
        wb(1'b0, 6'd0, 64'd0);
        check("dual_snoop_a", bus.out_a, 64'h77);
        check("dual_snoop_b", bus.out_b, 64'h77);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // full / backpressure, snoop of the non-head entry
        push(6'd0, 6'd0, 64'hA1, 64'hA2);
        tick();
        check("full_one_ready", 64'(bus.in_ready), 64'd1);
        push(6'd0, 6'd3, 64'hB1, 64'hB2);
        tick();
        check("full_ready_low", 64'(bus.in_ready), 64'd0);
        check("full_head_a", bus.out_a, 64'hA1);
        push(6'd0, 6'd0, 64'hC1, 64'hC2);
        bus.out_ready = 1'b1;
        wb(1'b1, 6'd3, 64'hCC);
        #1;
        check("full_ready_with_pop", 64'(bus.in_ready), 64'd0);
        tick();
        bus.in_valid = 1'b0;
        wb(1'b0, 6'd0, 64'd0);
        check("full_second_a", bus.out_a, 64'hB1);
        check("full_second_b_snooped", bus.out_b, 64'hCC);
        check("full_ready_back", 64'(bus.in_ready), 64'd1);
        tick();
        check("full_drained", 64'(bus.out_valid), 64'd0);
        check("full_no_c_a", bus.out_a, 64'd0);
        bus.out_ready = 1'b0;

        // flush while full, then flush with a live accept
        push(6'd0, 6'd0, 64'hD1, 64'hD2);
        tick();
        push(6'd0, 6'd0, 64'hE1, 64'hE2);
        tick();
        check("flush_full_ready", 64'(bus.in_ready), 64'd0);
        flush = 1'b1;
        push(6'd0, 6'd0, 64'hF1, 64'hF2);
        tick();
        check("flush_full_valid", 64'(bus.out_valid), 64'd0);
        check("flush_full_a", bus.out_a, 64'd0);
        check("flush_full_ready_after", 64'(bus.in_ready), 64'd1);
        flush = 1'b0;
        push(6'd0, 6'd0, 64'h61, 64'h62);
        tick();
        flush = 1'b1;
        push(6'd0, 6'd0, 64'h71, 64'h72);
        #1;
        check("flush_ready_during", 64'(bus.in_ready), 64'd1);
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_accept_dropped", 64'(bus.out_valid), 64'd0);
        tick();
        check("flush_stays_empty", 64'(bus.out_valid), 64'd0);
        check("flush_b_zero", bus.out_b, 64'd0);

        // reset with one op held
        push(6'd0, 6'd0, 64'h81, 64'h82);
        tick();
        bus.in_valid = 1'b0;
        check("rst_held_valid", 64'(bus.out_valid), 64'd1);
        reset = 1'b1;
        tick();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_a", bus.out_a, 64'd0);
        reset = 1'b0;
        tick();
        check("rst_release_ready", 64'(bus.in_ready), 64'd1);
        check("rst_release_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
